// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and validity helper
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade with load, up/down step and end flags
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       cnt_en,
  input  logic       reverse,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t cur;
  bcd_digit_t nxt_cnt;

  // An out-of-range digit (only reachable through X) counts as if it were 0.
  always_comb begin
    cur = bcd_valid(digit) ? digit : BCD_MIN;
    if (reverse) begin
      nxt_cnt = (cur == BCD_MIN) ? BCD_MAX : cur - 4'd1;
    end else begin
      nxt_cnt = (cur == BCD_MAX) ? BCD_MIN : cur + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_valid(load_digit) ? load_digit : BCD_MIN;
    end else if (cnt_en) begin
      digit <= nxt_cnt;
    end
  end

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-decade BCD up/down counter with load, wrap/saturate and chaining outputs
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                reverse,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] cnt_en;
  logic [DIGITS-1:0] bad_digit;
  // all_max[i] / all_min[i]: every digit below i sits at 9 / 0
  logic [DIGITS:0]   all_max;
  logic [DIGITS:0]   all_min;
  logic              hold_sat;

  assign all_max[0] = 1'b1;
  assign all_min[0] = 1'b1;

  assign tc       = enable & ~load & (reverse ? all_min[DIGITS] : all_max[DIGITS]);
  assign hold_sat = SATURATE & tc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign all_max[i+1]  = all_max[i] & at_max[i];
    assign all_min[i+1]  = all_min[i] & at_min[i];
    assign cnt_en[i]     = enable & ~hold_sat & (reverse ? all_min[i] : all_max[i]);
    assign bad_digit[i]  = ~bcd_valid(load_val[4*i +: 4]);

    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .cnt_en     (cnt_en[i]),
      .reverse    (reverse),
      .digit      (q[4*i +: 4]),
      .at_max     (at_max[i]),
      .at_min     (at_min[i])
    );
  end

  // tc already excludes load and idle cycles, so it is exactly the wrap/saturation event.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc;
      load_err <= load & (|bad_digit);
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter, wrap and saturate builds
module tb_bcd_updown_counter;

  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;

  logic        clk = 1'b0;
  logic        rst, enable, reverse, load;
  logic [15:0] load_val;
  logic [15:0] q_w, q_s;
  logic        tc_w, tc_s, wrap_w, wrap_s, le_w, le_s;

  int vectors     = 0;
  int miscompares = 0;

  int m_w, m_s;
  bit w_w, w_s, le_m;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .reverse(reverse), .load(load),
    .load_val(load_val), .q(q_w), .tc(tc_w), .wrap(wrap_w), .load_err(le_w)
  );

  bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .reverse(reverse), .load(load),
    .load_val(load_val), .q(q_s), .tc(tc_s), .wrap(wrap_s), .load_err(le_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int decode(input logic [15:0] lv, output bit bad);
    int v;
    int nib;
    v = 0;
    bad = 0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = int'(lv[4*d +: 4]);
      if (nib > 9) begin
        nib = 0;
        bad = 1;
      end
      v = v * 10 + nib;
    end
    return v;
  endfunction

  function automatic bit model_tc(input int m, input bit e, input bit rv, input bit ld);
    return e && !ld && (rv ? (m == 0) : (m == MAXV));
  endfunction

  task automatic model_step(inout int m, inout bit w, input bit sat,
                            input bit r, input bit e, input bit rv, input bit ld,
                            input logic [15:0] lv);
    bit bad;
    if (r) begin
      m = 0;
      w = 0;
    end else if (ld) begin
      m = decode(lv, bad);
      w = 0;
    end else if (e) begin
      if (rv ? (m == 0) : (m == MAXV)) begin
        w = 1;
        if (!sat) m = rv ? MAXV : 0;
      end else begin
        w = 0;
        m = rv ? m - 1 : m + 1;
      end
    end else begin
      w = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit rv, input bit ld, input logic [15:0] lv);
    bit bad;
    int unused_v;
    rst = r; enable = e; reverse = rv; load = ld; load_val = lv;
    #1;
    check("tc_wrap", tc_w, model_tc(m_w, e, rv, ld));
    check("tc_sat",  tc_s, model_tc(m_s, e, rv, ld));
    unused_v = decode(lv, bad);
    le_m = !r && ld && bad;
    model_step(m_w, w_w, 1'b0, r, e, rv, ld, lv);
    model_step(m_s, w_s, 1'b1, r, e, rv, ld, lv);
    @(posedge clk);
    #1;
    check("q_wrap",        q_w,    to_bcd(m_w));
    check("q_sat",         q_s,    to_bcd(m_s));
    check("wrap_wrap",     wrap_w, w_w);
    check("wrap_sat",      wrap_s, w_s);
    check("load_err_wrap", le_w,   le_m);
    check("load_err_sat",  le_s,   le_m);
    @(negedge clk);
  endtask

  function automatic logic [3:0] rand_nib();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    if ($urandom_range(0, 2) == 0) return ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd0;
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    logic [15:0] lv;
    m_w = 0; m_s = 0; w_w = 0; w_s = 0; le_m = 0;
    rst = 1'b1; enable = 1'b0; reverse = 1'b0; load = 1'b0; load_val = '0;
    @(negedge clk);

    step(1, 0, 0, 0, 16'h0000);
    check("reset_q", q_w, 16'h0000);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 16'h0000);
    check("count12", q_w, 16'h0012);

    step(0, 0, 0, 1, 16'h9998);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 16'h0000);
    check("wrap_up_q",  q_w,    16'h0000);
    check("wrap_up_p",  wrap_w, 1'b1);
    step(0, 0, 0, 0, 16'h0000);
    check("wrap_once",  wrap_w, 1'b0);

    step(0, 0, 0, 1, 16'h1000);
    step(0, 1, 1, 0, 16'h0000);
    check("borrow", q_w, 16'h0999);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 1, 1, 0, 16'h0000);
    check("wrap_down", q_w, 16'h9999);

    step(0, 0, 0, 1, 16'h9997);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'h0000);
    check("sat_hold", q_s, 16'h9999);

    step(0, 1, 0, 1, 16'h12A4);
    check("bad_load_q",   q_w,  16'h1204);
    check("bad_load_err", le_w, 1'b1);
    step(0, 0, 0, 0, 16'h0000);
    check("bad_load_once", le_w, 1'b0);

    step(0, 0, 0, 1, 16'h0450);
    step(0, 1, 0, 0, 16'h0000);
    step(1, 1, 0, 1, 16'h0450);
    check("rst_over_load", q_w, 16'h0000);
    for (int i = 0; i < 6; i++) step(0, 1, i % 2, 0, 16'h0000);

    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < DIGITS; d++) lv[4*d +: 4] = rand_nib();
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
